// File: rtl/edge_detect_multi.sv
`timescale 1ns/1ps
// edge_detect_multi
//   Multi-channel synchroniser, optional debouncer and edge detector. Each
//   channel produces a filtered level, a one-cycle edge pulse selected by
//   edge_mode, and a sticky flag. irq is the registered OR of the flags.
//
//   Build option: define EDGE_DETECT_DEBOUNCE_EN to add the per-channel
//   debounce counters. Without it the level follows the synchronised
//   input every cycle and DB_CYCLES has no effect.
//
//   Ports
//     Clk100MHz   in   1         clock, rising edge
//     reset_n     in   1         asynchronous active-low reset
//     sig         in   CHANNELS  raw asynchronous inputs
//     edge_mode   in   2         00 none, 01 rising, 10 falling, 11 both
//     flag_clr    in   CHANNELS  per-channel sticky-flag clear
//     sig_level   out  CHANNELS  registered filtered level
//     sig_pulse   out  CHANNELS  one-cycle pulse on a qualifying edge
//     sig_flag    out  CHANNELS  sticky edge flags
//     irq         out  1         registered OR of sig_flag
module edge_detect_multi #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DB_CYCLES   = 16
) (
  input  logic                Clk100MHz,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] sig,
  input  logic [1:0]          edge_mode,
  input  logic [CHANNELS-1:0] flag_clr,
  output logic [CHANNELS-1:0] sig_level,
  output logic [CHANNELS-1:0] sig_pulse,
  output logic [CHANNELS-1:0] sig_flag,
  output logic                irq
);

  if (CHANNELS < 1 || CHANNELS > 32) begin : g_bad_channels
    $error("edge_detect_multi: CHANNELS must be 1..32");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("edge_detect_multi: SYNC_STAGES must be 2..4");
  end
  if (DB_CYCLES < 2 || DB_CYCLES > 65535) begin : g_bad_db
    $error("edge_detect_multi: DB_CYCLES must be 2..65535");
  end

  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] s;
  logic [CHANNELS-1:0] level_q, level_d;
  logic [CHANNELS-1:0] pulse_q, pulse_d;
  logic [CHANNELS-1:0] flag_q, flag_d;
  logic                irq_q, irq_d;
  logic [CHANNELS-1:0] rise, fall;

  // Synchroniser chain
  always_ff @(posedge Clk100MHz or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      sync_q[0] <= sig;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

`ifdef EDGE_DETECT_DEBOUNCE_EN
  localparam int unsigned CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  logic [CW-1:0] cnt_q [CHANNELS];
  logic [CW-1:0] cnt_d [CHANNELS];

  // The counter measures how long s has disagreed with the accepted level;
  // any agreement restarts it, and acceptance returns it to zero.
  always_comb begin
    level_d = level_q;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      cnt_d[i] = '0;
      if (s[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          level_d[i] = s[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge Clk100MHz or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end
`else
  assign level_d = s;
`endif

  // Edges are taken from the level update itself, so a change of edge_mode
  // alone can never produce a pulse.
  always_comb begin
    rise    = level_d & ~level_q;
    fall    = ~level_d & level_q;
    pulse_d = '0;
    if (edge_mode[0]) pulse_d = pulse_d | rise;
    if (edge_mode[1]) pulse_d = pulse_d | fall;
    // A new edge outranks a clear arriving on the same cycle.
    flag_d  = pulse_d | (flag_q & ~flag_clr);
    irq_d   = |flag_q;
  end

  always_ff @(posedge Clk100MHz or negedge reset_n) begin
    if (!reset_n) begin
      level_q <= '0;
      pulse_q <= '0;
      flag_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      pulse_q <= pulse_d;
      flag_q  <= flag_d;
      irq_q   <= irq_d;
    end
  end

  assign sig_level = level_q;
  assign sig_pulse = pulse_q;
  assign sig_flag  = flag_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_edge_detect_multi.sv
`timescale 1ns/1ps
module tb_edge_detect_multi;

  localparam int CH = 4;
  localparam int SS = 2;
  localparam int DB = 4;
`ifdef EDGE_DETECT_DEBOUNCE_EN
  localparam int DBW = DB;
`else
  localparam int DBW = 1;
`endif
  localparam int LAT = SS + DBW;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [CH-1:0] sig;
  logic [1:0]    edge_mode;
  logic [CH-1:0] flag_clr;
  logic [CH-1:0] sig_level, sig_pulse, sig_flag;
  logic          irq;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  edge_detect_multi #(
    .CHANNELS   (CH),
    .SYNC_STAGES(SS),
    .DB_CYCLES  (DB)
  ) dut (
    .Clk100MHz(clk),
    .reset_n  (reset_n),
    .sig      (sig),
    .edge_mode(edge_mode),
    .flag_clr (flag_clr),
    .sig_level(sig_level),
    .sig_pulse(sig_pulse),
    .sig_flag (sig_flag),
    .irq      (irq)
  );

  // Reference model: level flips once the synchronised input has disagreed
  // with it for the last DBW visible samples.
  logic [CH-1:0] m_level, m_pulse, m_flag;
  logic          m_irq;
  logic [CH-1:0] sig_hist [$];
  logic [CH-1:0] s_hist [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_level = '0;
    m_pulse = '0;
    m_flag  = '0;
    m_irq   = 1'b0;
    sig_hist.delete();
    s_hist.delete();
  endtask

  task automatic model_step();
    logic [CH-1:0] nl, rise, fall, np, s_now;
    bit all_diff;
    nl = m_level;
    for (int ch = 0; ch < CH; ch++) begin
      if (s_hist.size() >= DBW) begin
        all_diff = 1'b1;
        for (int k = 0; k < DBW; k++)
          if (s_hist[s_hist.size()-1-k][ch] == m_level[ch]) all_diff = 1'b0;
        if (all_diff) nl[ch] = ~m_level[ch];
      end
    end
    rise = nl & ~m_level;
    fall = ~nl & m_level;
    np = '0;
    if (edge_mode[0]) np = np | rise;
    if (edge_mode[1]) np = np | fall;
    m_irq   = |m_flag;
    m_flag  = np | (m_flag & ~flag_clr);
    m_pulse = np;
    m_level = nl;
    sig_hist.push_back(sig);
    if (sig_hist.size() > SS) void'(sig_hist.pop_front());
    s_now = (sig_hist.size() == SS) ? sig_hist[0] : '0;
    s_hist.push_back(s_now);
    if (s_hist.size() > DBW) void'(s_hist.pop_front());
  endtask

  task automatic compare_all();
    check("level", 32'(sig_level), 32'(m_level));
    check("pulse", 32'(sig_pulse), 32'(m_pulse));
    check("flag",  32'(sig_flag),  32'(m_flag));
    check("irq",   32'(irq),       32'(m_irq));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    check("rst_zero_outputs", {sig_level, sig_pulse, sig_flag, 3'b0, irq}, 32'h0);
    compare_all();
    #1;
    reset_n = 1'b1;
  endtask

  int hold [CH];
  int cnt_dut, cnt_mod;

  initial begin
    reset_n   = 1'b0;
    sig       = '0;
    edge_mode = 2'b00;
    flag_clr  = '0;
    model_reset();
    #2;
    check("reset_state", {sig_level, sig_pulse, sig_flag, 3'b0, irq}, 32'h0);
    #20;
    reset_n = 1'b1;

    // Falling-only mode: rise is silent, fall pulses after LAT edges.
    edge_mode = 2'b10;
    sig[0] = 1'b1;
    for (int k = 0; k < 20; k++) cycle();
    check("fall_mode_rise_silent", 32'(sig_flag[0]), 32'h0);
    check("ch0_level_high", 32'(sig_level[0]), 32'h1);
    sig[0] = 1'b0;
    for (int k = 1; k <= LAT + 2; k++) begin
      cycle();
      check("fall_pulse_dut", 32'(sig_pulse[0]), 32'(k == LAT));
      check("fall_pulse_model", 32'(m_pulse[0]), 32'(k == LAT));
      check("fall_flag_dut", 32'(sig_flag[0]), 32'(k >= LAT));
      check("fall_irq_dut", 32'(irq), 32'(k >= LAT + 1));
      check("fall_irq_model", 32'(m_irq), 32'(k >= LAT + 1));
    end
    flag_clr[0] = 1'b1;
    cycle();
    check("flag0_cleared", 32'(sig_flag[0]), 32'h0);
    flag_clr[0] = 1'b0;
    cycle();
    check("irq_drops", 32'(irq), 32'h0);

    // Clear coinciding with the pulse edge loses to the set.
    edge_mode = 2'b01;
    sig[3] = 1'b1;
    for (int k = 1; k < LAT; k++) cycle();
    flag_clr[3] = 1'b1;
    cycle();
    check("ch3_pulse", 32'(sig_pulse[3]), 32'h1);
    check("ch3_set_wins", 32'(sig_flag[3]), 32'h1);
    cycle();
    check("ch3_clr_next", 32'(sig_flag[3]), 32'h0);
    flag_clr[3] = 1'b0;

    // Both-edge mode gives two pulses; none-mode gives none.
    for (int pass = 0; pass < 2; pass++) begin
      edge_mode = (pass == 0) ? 2'b11 : 2'b00;
      cnt_dut = 0;
      cnt_mod = 0;
      sig[2] = 1'b1;
      for (int k = 0; k < 10; k++) begin
        cycle();
        cnt_dut += int'(sig_pulse[2]);
        cnt_mod += int'(m_pulse[2]);
      end
      sig[2] = 1'b0;
      for (int k = 0; k < 15; k++) begin
        cycle();
        cnt_dut += int'(sig_pulse[2]);
        cnt_mod += int'(m_pulse[2]);
      end
      check("ch2_pulse_count_dut", 32'(cnt_dut), (pass == 0) ? 32'd2 : 32'd0);
      check("ch2_pulse_count_model", 32'(cnt_mod), (pass == 0) ? 32'd2 : 32'd0);
    end

`ifdef EDGE_DETECT_DEBOUNCE_EN
    // A dip shorter than the debounce window is ignored.
    edge_mode = 2'b11;
    sig[1] = 1'b1;
    for (int k = 0; k < 12; k++) cycle();
    sig[1] = 1'b0;
    for (int k = 0; k < 3; k++) cycle();
    sig[1] = 1'b1;
    cnt_dut = 0;
    for (int k = 0; k < 12; k++) begin
      cycle();
      cnt_dut += int'(sig_pulse[1]);
      check("ch1_level_held", 32'(sig_level[1]), 32'h1);
    end
    check("ch1_glitch_no_pulse", 32'(cnt_dut), 32'h0);
`else
    // Without filtering, a one-cycle glitch shows both edges.
    edge_mode = 2'b11;
    sig[1] = 1'b1;
    cycle();
    sig[1] = 1'b0;
    cnt_dut = 0;
    cnt_mod = 0;
    for (int k = 0; k < 8; k++) begin
      cycle();
      cnt_dut += int'(sig_pulse[1]);
      cnt_mod += int'(m_pulse[1]);
    end
    check("ch1_glitch_two_pulses_dut", 32'(cnt_dut), 32'd2);
    check("ch1_glitch_two_pulses_model", 32'(cnt_mod), 32'd2);
`endif

    // Reset in the middle of a count, then full latency from release.
    edge_mode = 2'b01;
    sig[0] = 1'b0;
    for (int k = 0; k < 12; k++) cycle();
    sig[0] = 1'b1;
    for (int k = 0; k < 4; k++) cycle();
    do_reset();
    cnt_dut = -1;
    cnt_mod = -1;
    for (int k = 1; k <= LAT + 4; k++) begin
      cycle();
      if (sig_pulse[0] && cnt_dut < 0) cnt_dut = k;
      if (m_pulse[0] && cnt_mod < 0) cnt_mod = k;
    end
    check("post_reset_latency_dut", 32'(cnt_dut), 32'(LAT));
    check("post_reset_latency_model", 32'(cnt_mod), 32'(LAT));

    // Randomised phase.
    for (int ch = 0; ch < CH; ch++) hold[ch] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int ch = 0; ch < CH; ch++) begin
        if (hold[ch] == 0) begin
          sig[ch]  = 1'($urandom_range(0, 1));
          hold[ch] = int'($urandom_range(1, 3 * DB));
        end else begin
          hold[ch]--;
        end
        flag_clr[ch] = ($urandom_range(0, 7) == 0);
      end
      if ($urandom_range(0, 49) == 0) edge_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 999) == 0) do_reset();
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
